rom_dl_sequencer: RTL and testbench
===================================

Name: rom_dl_sequencer

Overview:
- Source (writer) side of the ROM download bus that top consumes (dl_addr/dl_data/dl_wr).
- Accepts a ready/valid byte stream from the HPS/ioctl bridge and issues single-cycle write strobes at incrementing addresses; top decodes prog ROM (0x0000–0x3FFF) and vector ROM (0x4000–0x4FFF) from the address.
- Holds the game core in reset (drives top's active-low btnCpuReset) until the full image is loaded.
- Reports a 16-bit byte checksum and load status.

Parameters:
- TOTAL_BYTES, 20480, image length in bytes (0x4000 prog + 0x1000 vector).
- WR_GAP, 0, idle cycles forced between accepted bytes (0 = one byte per clk).
- RESET_HOLD, 16, clk cycles core_rst_l stays low after the last write.

Ports:
- clk  in  1  system clock (same clk as top)
- rst_l  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins or restarts a load
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks final byte supplied by the source
- s_ready  out  1  byte accepted when s_valid & s_ready
- dl_addr  out  25  write address to top
- dl_data  out  8  write data to top
- dl_wr  out  1  one-cycle write strobe
- core_rst_l  out  1  to top btnCpuReset; 0 holds the core in reset
- busy  out  1  load in progress (LOAD or HOLD)
- done  out  1  image complete, core released
- error  out  1  short image (s_last before TOTAL_BYTES)
- checksum  out  16  sum of accepted bytes, mod 2^16

Behaviour:
- Reset (async, rst_l=0): all outputs 0, including core_rst_l=0; state IDLE; byte count and gap counter 0. Outputs drop in the same cycle rst_l falls, including mid-load.
- States: IDLE, LOAD, HOLD, DONE, ERR.
- IDLE:
  - s_ready=0; core_rst_l keeps its previous value (0 after reset).
  - start -> LOAD: count=0, checksum=0, error=0, done=0, core_rst_l=0.
- LOAD:
  - busy=1; s_ready=1 when gap counter=0.
  - On acceptance at cycle N: in cycle N+1 dl_wr=1, dl_addr=count, dl_data=s_data. dl_wr is exactly one cycle; dl_addr/dl_data hold their values until the next write.
  - On acceptance: count+1; checksum+=s_data (16-bit wrap); gap counter=WR_GAP.
  - s_ready=0 while the gap counter is nonzero. The next acceptance is at cycle N+1+WR_GAP at the earliest.
  - Accepted byte with count+1==TOTAL_BYTES -> HOLD; s_last on this byte is ignored.
  - Accepted byte with s_last=1 and count+1<TOTAL_BYTES -> ERR; that byte is still written.
  - s_valid low: no change, no stall penalty.
- HOLD:
  - s_ready=0; core_rst_l=0.
  - Hold timer counts RESET_HOLD cycles, starting the cycle after the final dl_wr -> DONE.
- DONE: done=1, busy=0, core_rst_l=1, s_ready=0. Extra stream bytes are not accepted.
- ERR: error=1, busy=0, core_rst_l=0, s_ready=0; remains until start.
- start in any state restarts: -> LOAD, count/checksum/error/done cleared, core_rst_l=0, pending gap cleared. If an acceptance coincides with start, start wins and the byte is not accepted (s_ready is forced 0 that cycle).
- Widths:
  - count is 25 bits and compares against TOTAL_BYTES.
  - dl_addr never exceeds TOTAL_BYTES-1.
  - TOTAL_BYTES must be at least 1; RESET_HOLD must be at least 1.

Decomposition:
- Package rom_dl_pkg:
  - state enum dl_state_t {IDLE, LOAD, HOLD, DONE, ERR}
  - PROG_ROM_BYTES=0x4000, VEC_ROM_BYTES=0x1000, DL_ADDR_W=25
  - DEFAULT_TOTAL = PROG_ROM_BYTES+VEC_ROM_BYTES
- Single module, no sub-module. The gap and hold timers share one down-counter.

Test Plan:
1. TOTAL_BYTES=8, WR_GAP=0; start, then bytes 0x01..0x08 with s_valid held high -> 8 consecutive dl_wr pulses at dl_addr 0..7 with matching data; checksum=0x0024; done=1 and core_rst_l=1 exactly 16 cycles after the last dl_wr.
2. WR_GAP=2, s_valid constantly high -> s_ready pattern 1,0,0 repeating; dl_wr every 3rd cycle; addresses contiguous.
3. TOTAL_BYTES=8, s_last on 5th byte -> 5 writes (addr 0..4), error=1, done=0, core_rst_l stays 0. A following start clears error and accepts a byte to addr 0.
4. start pulse after 3 bytes accepted -> next accepted byte written at dl_addr 0; checksum restarted from 0; start coinciding with s_valid does not accept that byte.
5. rst_l driven low between clock edges mid-load -> dl_wr, s_ready, busy, core_rst_l go 0 immediately with no clk edge; state IDLE after release.
6. TOTAL_BYTES=300, all bytes 0xFF -> checksum=0x2AD4 (wraps); last write at dl_addr 0x12B; done asserted.

Source files
------------

// File: rtl/rom_dl_sequencer_pkg.sv
//==============================================================================
// Package     : rom_dl_pkg
// Description : Shared types and sizes for the ROM download sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rom_dl_pkg;

  localparam int PROG_ROM_BYTES = 'h4000;
  localparam int VEC_ROM_BYTES  = 'h1000;
  localparam int DL_ADDR_W      = 25;
  localparam int DEFAULT_TOTAL  = PROG_ROM_BYTES + VEC_ROM_BYTES;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } dl_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_dl_sequencer_if.sv
//==============================================================================
// Interface   : rom_dl_sequencer_if
// Description : Byte stream in (ready/valid) and ROM download write bus out.
//               slave  = the sequencer, master = the stream source / bus sink.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rom_dl_sequencer_if;
  import rom_dl_pkg::*;

  logic                 s_valid;
  logic [7:0]           s_data;
  logic                 s_last;
  logic                 s_ready;
  logic [DL_ADDR_W-1:0] dl_addr;
  logic [7:0]           dl_data;
  logic                 dl_wr;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, dl_addr, dl_data, dl_wr
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, dl_addr, dl_data, dl_wr
  );

endinterface

`default_nettype wire

// File: rtl/rom_dl_sequencer.sv
//==============================================================================
// Module      : rom_dl_sequencer
// Description : Turns an incoming byte stream into single-cycle ROM download
//               writes at incrementing addresses, keeps the game core in reset
//               until the whole image is in, and reports checksum and status.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int TOTAL_BYTES = DEFAULT_TOTAL,  // image length, must be >= 1
  parameter int WR_GAP      = 0,              // idle cycles between accepted bytes
  parameter int RESET_HOLD  = 16              // core reset hold after last write, >= 1
) (
  input  wire logic        clk,
  input  wire logic        rst_l,
  input  wire logic        start,
  rom_dl_sequencer_if.slave bus,
  output logic             core_rst_l,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      checksum
);

  // One down-counter serves both the inter-byte gap and the reset hold, so it
  // has to be wide enough for whichever is larger.
  localparam int c_TMR_MAX = (WR_GAP > RESET_HOLD) ? WR_GAP : RESET_HOLD;
  localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX + 1) : 1;

  localparam logic [DL_ADDR_W-1:0] c_TOTAL   = DL_ADDR_W'(TOTAL_BYTES);
  localparam logic [c_TMR_W-1:0]   c_GAP     = c_TMR_W'(WR_GAP);
  // The hold count includes the cycle carrying the final write strobe.
  localparam logic [c_TMR_W-1:0]   c_HOLD_LD = c_TMR_W'(RESET_HOLD - 1);

  dl_state_t            r_state;
  logic [DL_ADDR_W-1:0] r_count;
  logic [c_TMR_W-1:0]   r_tmr;
  logic [DL_ADDR_W-1:0] r_addr;
  logic [7:0]           r_data;
  logic                 r_wr;
  logic                 r_core_rst_l;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [15:0]          r_sum;

  logic                 w_ready;
  logic                 w_accept;
  logic [DL_ADDR_W-1:0] w_count_nxt;

  // start takes priority over a byte presented in the same cycle.
  assign w_ready     = (r_state == LOAD) && (r_tmr == '0) && !start;
  assign w_accept    = bus.s_valid && w_ready;
  assign w_count_nxt = r_count + 1'b1;

  // Load sequencing: stream acceptance, write strobe generation, gap/hold timing.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_tmr        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wr         <= 1'b0;
      r_core_rst_l <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_sum        <= '0;
    end else begin
      r_wr <= 1'b0;
      if (start) begin
        r_state      <= LOAD;
        r_count      <= '0;
        r_tmr        <= '0;
        r_sum        <= '0;
        r_error      <= 1'b0;
        r_done       <= 1'b0;
        r_core_rst_l <= 1'b0;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          LOAD: begin
            if (w_accept) begin
              r_wr    <= 1'b1;
              r_addr  <= r_count;
              r_data  <= bus.s_data;
              r_count <= w_count_nxt;
              r_sum   <= r_sum + {8'h00, bus.s_data};
              if (w_count_nxt == c_TOTAL) begin
                // Full image: s_last on this byte is irrelevant.
                r_state <= HOLD;
                r_tmr   <= c_HOLD_LD;
              end else if (bus.s_last) begin
                r_state <= ERR;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_tmr   <= '0;
              end else begin
                r_tmr <= c_GAP;
              end
            end else if (r_tmr != '0) begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          HOLD: begin
            if (r_tmr == '0) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_core_rst_l <= 1'b1;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          default: begin
            // IDLE, DONE and ERR only leave on start.
          end
        endcase
      end
    end
  end

  assign bus.s_ready = w_ready;
  assign bus.dl_addr = r_addr;
  assign bus.dl_data = r_data;
  assign bus.dl_wr   = r_wr;
  assign core_rst_l  = r_core_rst_l;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign checksum    = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_rom_dl_sequencer.sv
//==============================================================================
// Module      : tb_rom_dl_sequencer
// Description : Self-checking bench for rom_dl_sequencer. Instance A is a small
//               8-byte image with no gap; instance B is a 300-byte image with a
//               two-cycle gap. Expected writes go into per-instance queues.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rom_dl_sequencer;
  import rom_dl_pkg::*;

  typedef struct {
    int                   cyc;
    logic [DL_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        core_rst_l_a, busy_a, done_a, error_a;
  logic        core_rst_l_b, busy_b, done_b, error_b;
  logic [15:0] checksum_a, checksum_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  wr_t                  sb_a[$];
  wr_t                  sb_b[$];
  wr_t                  e_a, e_b;
  logic [DL_ADDR_W-1:0] m_addr_a = '0;
  logic [DL_ADDR_W-1:0] m_addr_b = '0;

  rom_dl_sequencer_if bus_a();
  rom_dl_sequencer_if bus_b();

  rom_dl_sequencer #(.TOTAL_BYTES(8), .WR_GAP(0), .RESET_HOLD(16)) u_dut_a (
    .clk(clk), .rst_l(rst_l), .start(start_a), .bus(bus_a.slave),
    .core_rst_l(core_rst_l_a), .busy(busy_a), .done(done_a),
    .error(error_a), .checksum(checksum_a)
  );

  rom_dl_sequencer #(.TOTAL_BYTES(300), .WR_GAP(2), .RESET_HOLD(4)) u_dut_b (
    .clk(clk), .rst_l(rst_l), .start(start_b), .bus(bus_b.slave),
    .core_rst_l(core_rst_l_b), .busy(busy_b), .done(done_b),
    .error(error_b), .checksum(checksum_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on instance b (0 = A, 1 = B), check s_ready
  // against the bench's expectation and queue the write an accept should cause.
  task automatic drive(input bit b, input logic v, input logic [7:0] d,
                       input logic l, input logic st, input logic exp_rdy);
    wr_t e;
    if (!b) begin
      bus_a.s_valid = v; bus_a.s_data = d; bus_a.s_last = l; start_a = st;
    end else begin
      bus_b.s_valid = v; bus_b.s_data = d; bus_b.s_last = l; start_b = st;
    end
    #1;
    if (!b) begin
      check("a_s_ready", bus_a.s_ready, exp_rdy);
      if (st) m_addr_a = '0;
      if (v && exp_rdy) begin
        e.cyc = cyc + 1; e.addr = m_addr_a; e.data = d;
        sb_a.push_back(e);
        m_addr_a = m_addr_a + 1'b1;
      end
    end else begin
      check("b_s_ready", bus_b.s_ready, exp_rdy);
      if (st) m_addr_b = '0;
      if (v && exp_rdy) begin
        e.cyc = cyc + 1; e.addr = m_addr_b; e.data = d;
        sb_b.push_back(e);
        m_addr_b = m_addr_b + 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Write monitor for A: every strobe must match the oldest queued write in cycle, address and data.
  always @(negedge clk) begin
    if (bus_a.dl_wr === 1'b1) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_wr", 32'(bus_a.dl_addr), 32'hFFFF_FFFF);
      end else begin
        e_a = sb_a.pop_front();
        check("a_wr_cycle", cyc, e_a.cyc);
        check("a_wr_addr", 32'(bus_a.dl_addr), 32'(e_a.addr));
        check("a_wr_data", 32'(bus_a.dl_data), 32'(e_a.data));
      end
    end else if (sb_a.size() != 0 && sb_a[0].cyc <= cyc) begin
      check("a_missing_wr", 32'(bus_a.dl_wr), 32'd1);
      void'(sb_a.pop_front());
    end
  end

  // Write monitor for B.
  always @(negedge clk) begin
    if (bus_b.dl_wr === 1'b1) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_wr", 32'(bus_b.dl_addr), 32'hFFFF_FFFF);
      end else begin
        e_b = sb_b.pop_front();
        check("b_wr_cycle", cyc, e_b.cyc);
        check("b_wr_addr", 32'(bus_b.dl_addr), 32'(e_b.addr));
        check("b_wr_data", 32'(bus_b.dl_data), 32'(e_b.data));
      end
    end else if (sb_b.size() != 0 && sb_b[0].cyc <= cyc) begin
      check("b_missing_wr", 32'(bus_b.dl_wr), 32'd1);
      void'(sb_b.pop_front());
    end
  end

  initial begin
    bus_a.s_valid = 1'b0; bus_a.s_data = 8'h00; bus_a.s_last = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_data = 8'h00; bus_b.s_last = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_dl_wr", bus_a.dl_wr, 1'b0);
    check("rst_dl_addr", 32'(bus_a.dl_addr), 32'd0);
    check("rst_dl_data", bus_a.dl_data, 8'h00);
    check("rst_core_rst_l", core_rst_l_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_error", error_a, 1'b0);
    check("rst_checksum", checksum_a, 16'h0000);
    check("rst_b_core_rst_l", core_rst_l_b, 1'b0);
    rst_l = 1'b1;
    @(negedge clk);

    // Full 8-byte load, back-to-back, then reset hold of 16 cycles
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t1_busy_after_start", busy_a, 1'b1);
    for (int i = 1; i <= 8; i++) drive(0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    check("t1_checksum", checksum_a, 16'h0024);
    check("t1_busy_in_hold", busy_a, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("t1_done_timing", done_a, (k == 16));
      check("t1_core_rst_timing", core_rst_l_a, (k == 16));
    end
    check("t1_busy_done", busy_a, 1'b0);
    drive(0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("t1_done_held", done_a, 1'b1);
    check("t1_checksum_held", checksum_a, 16'h0024);

    // Short image: s_last on the 5th of 8 bytes
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t3_done_cleared", done_a, 1'b0);
    check("t3_core_rst_low", core_rst_l_a, 1'b0);
    for (int i = 1; i <= 5; i++) drive(0, 1'b1, 8'(i), (i == 5), 1'b0, 1'b1);
    check("t3_error", error_a, 1'b1);
    check("t3_done", done_a, 1'b0);
    check("t3_busy", busy_a, 1'b0);
    check("t3_core_rst_l", core_rst_l_a, 1'b0);
    check("t3_checksum", checksum_a, 16'h000F);
    drive(0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    check("t3_error_sticky", error_a, 1'b1);
    // start together with a valid byte: start wins, byte dropped
    drive(0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    check("t3_error_cleared", error_a, 1'b0);
    check("t3_busy_restart", busy_a, 1'b1);
    drive(0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    check("t3_checksum_restart", checksum_a, 16'h00A5);

    // Restart after 3 accepted bytes
    drive(0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
    check("t4_checksum_3", checksum_a, 16'h00D5);
    drive(0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    check("t4_checksum_cleared", checksum_a, 16'h0000);
    drive(0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    check("t4_checksum_new", checksum_a, 16'h0011);

    // Asynchronous reset in the middle of a write strobe
    bus_a.s_valid = 1'b1; bus_a.s_data = 8'h42; bus_a.s_last = 1'b0; start_a = 1'b0;
    @(posedge clk);
    #2;
    check("t5_wr_before_rst", bus_a.dl_wr, 1'b1);
    check("t5_addr_before_rst", 32'(bus_a.dl_addr), 32'd1);
    check("t5_ready_before_rst", bus_a.s_ready, 1'b1);
    rst_l = 1'b0;
    #1;
    check("t5_dl_wr_async", bus_a.dl_wr, 1'b0);
    check("t5_s_ready_async", bus_a.s_ready, 1'b0);
    check("t5_busy_async", busy_a, 1'b0);
    check("t5_core_rst_async", core_rst_l_a, 1'b0);
    check("t5_checksum_async", checksum_a, 16'h0000);
    check("t5_addr_async", 32'(bus_a.dl_addr), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    drive(0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("t5_idle_busy", busy_a, 1'b0);
    check("t5_idle_no_wr", bus_a.dl_wr, 1'b0);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 300 bytes of 0xFF with a two-cycle gap: ready 1,0,0 and wrapping checksum
    drive(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
      drive(1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    check("t6_checksum", checksum_b, 16'h2AD4);
    check("t6_last_addr", 32'(bus_b.dl_addr), 32'h12B);
    check("t6_busy_hold", busy_b, 1'b1);
    check("t6_done_early", done_b, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t6_done_early2", done_b, 1'b0);
    check("t6_core_rst_hold", core_rst_l_b, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t6_done", done_b, 1'b1);
    check("t6_core_rst_release", core_rst_l_b, 1'b1);
    check("t6_busy_done", busy_b, 1'b0);
    check("t6_error", error_b, 1'b0);

    // Asynchronous reset from DONE pulls the core back into reset at once
    #2;
    rst_l = 1'b0;
    #1;
    check("t6_core_rst_async", core_rst_l_b, 1'b0);
    check("t6_done_async", done_b, 1'b0);
    check("t6_checksum_async", checksum_b, 16'h0000);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    @(negedge clk);

    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
